micro_sequencer: RTL

Microprogram sequencer for the microcoded CPU. It owns the microprogram counter (MPC) and steps each microinstruction through fetch, execute, optional memory wait, flag latch and next-address phases. It drives the datapath execute strobe, the memory start strobe and the `set_F` flag-latch strobe that the flag unit consumes. It forms the next MPC from the microinstruction's next-address field with JAMZ/JAMN high-bit forcing and JMPC MBR-ORing. It sits between the synchronous control store, the datapath and the memory interface.

---
 rtl/micro_sequencer.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/micro_sequencer.sv
// Microprogram sequencer: owns the MPC and steps each microinstruction
// through fetch, execute, memory wait, flag latch and next-address phases.
module micro_sequencer #(
  parameter int                ADDR_W     = 9,
  parameter int                MBR_W      = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter logic [ADDR_W-1:0] HALT_ADDR  = '1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              halt_req,
  input  logic [ADDR_W-1:0] mir_next_addr,
  input  logic              mir_jamz,
  input  logic              mir_jamn,
  input  logic              mir_jmpc,
  input  logic              mir_mem_req,
  input  logic [MBR_W-1:0]  mbr,
  input  logic              z_flag,
  input  logic              n_flag,
  input  logic              mem_done,
  output logic [ADDR_W-1:0] mpc,
  output logic              exec_en,
  output logic              mem_start,
  output logic              set_F,
  output logic              halted,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEMW  = 3'd3,
    S_FLAG  = 3'd4,
    S_NEXT  = 3'd5,
    S_HALT  = 3'd6
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] mpc_q;
  logic [ADDR_W-1:0] next_q;
  logic [MBR_W-1:0]  mbr_q;
  logic              jamz_q;
  logic              jamn_q;
  logic              jmpc_q;
  logic              z_q;
  logic              n_q;
  logic              halt_pend_q;
  logic              halt_pend_d;

  logic [ADDR_W-1:0] mbr_ext;
  logic [ADDR_W-1:0] jam_ext;
  logic [ADDR_W-1:0] addr_d;
  logic              jam_bit;
  logic              in_uinstr;
  logic              to_halt;

  // Pure OR composition: no carry path, so no wrap is possible.
  assign mbr_ext = {{(ADDR_W-MBR_W){1'b0}}, mbr_q};
  assign jam_bit = (jamz_q & z_q) | (jamn_q & n_q);
  assign jam_ext = {jam_bit, {(ADDR_W-1){1'b0}}};
  assign addr_d  = next_q | (jmpc_q ? mbr_ext : '0) | jam_ext;

  assign in_uinstr = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                     (state_q == S_MEMW)  || (state_q == S_FLAG) ||
                     (state_q == S_NEXT);

  always_comb begin
    state_d = S_IDLE;
    unique case (state_q)
      S_IDLE:  state_d = start ? S_FETCH : S_IDLE;
      S_FETCH: state_d = S_EXEC;
      S_EXEC:  state_d = mir_mem_req ? S_MEMW : S_FLAG;
      S_MEMW:  state_d = mem_done ? S_FLAG : S_MEMW;
      S_FLAG:  state_d = S_NEXT;
      S_NEXT: begin
        if (halt_pend_q || (addr_d == HALT_ADDR)) state_d = S_HALT;
        else state_d = S_FETCH;
      end
      S_HALT:  state_d = start ? S_FETCH : S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  assign to_halt = (state_q == S_NEXT) && (state_d == S_HALT);

  always_comb begin
    halt_pend_d = halt_pend_q;
    if (to_halt) halt_pend_d = 1'b0;
    else if (in_uinstr && halt_req) halt_pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      next_q <= '0;
      mbr_q  <= '0;
      jamz_q <= 1'b0;
      jamn_q <= 1'b0;
      jmpc_q <= 1'b0;
    end else if (state_q == S_EXEC) begin
      next_q <= mir_next_addr;
      mbr_q  <= mbr;
      jamz_q <= mir_jamz;
      jamn_q <= mir_jamn;
      jmpc_q <= mir_jmpc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else if (state_q == S_FLAG) begin
      z_q <= z_flag;
      n_q <= n_flag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mpc_q <= RESET_ADDR;
    else if (state_q == S_NEXT) mpc_q <= addr_d;
  end

  assign mpc       = mpc_q;
  assign state     = state_q;
  assign exec_en   = (state_q == S_EXEC);
  assign mem_start = (state_q == S_EXEC) && mir_mem_req;
  assign set_F     = (state_q == S_FLAG);
  assign halted    = (state_q == S_HALT);

endmodule
